// File: rtl/video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// video_timing_ctrl
//
// Raster timing sequencer for the three TMDS encoder/serializer lanes. Runs
// horizontal/vertical pixel counters on the pixel clock and generates the
// display-enable, sync control words, pixel requests and line/frame markers.
// Also tracks source underruns (DE high while the source has no data).
//
// State table (top FSM)
//   ST_IDLE | counters parked at (0,0), no requests, syncs inactive
//   ST_RUN  | raster running; leaves only at the frame wrap with
//           | videoEnable low, so a frame always completes
//
// State table (horizontal phase FSM, vertical phase FSM is identical)
//   H_ACT   | hCount in [0, H_ACTIVE)
//   H_FP    | front porch
//   H_SY    | sync pulse
//   H_BP    | back porch
//
// Ports
//   pixelClk       in   pixel clock (only clock)
//   rstN           in   asynchronous active-low reset
//   videoEnable    in   run request, sampled at frame boundaries while running
//   pixelValid     in   source has pixel data this cycle
//   clearUnderrun  in   clears the sticky underrun flag
//   pixelReq       out  source must present (pixelX, pixelY) next cycle
//   pixelX/pixelY  out  coordinates of the requested pixel (held otherwise)
//   DE             out  display enable to all three encoders
//   controlBus0    out  {vsync, hsync} to the blue lane
//   controlBus1/2  out  green/red control words, always 2'b00
//   frameStart     out  pulse with the first pixel request of a frame
//   lineStart      out  pulse at hCount==0 of every line while running
//   underrun       out  sticky underrun flag
//   running        out  high while the top FSM is in ST_RUN
//
// Pipeline: counters (t) -> stage 1 request/markers (t+1) -> stage 2
// DE/sync/underrun check (t+2). Totals must not exceed 4095.
// ---------------------------------------------------------------------------
module video_timing_ctrl #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        pixelClk,
    input  logic        rstN,
    input  logic        videoEnable,
    input  logic        pixelValid,
    input  logic        clearUnderrun,
    output logic        pixelReq,
    output logic [11:0] pixelX,
    output logic [11:0] pixelY,
    output logic        DE,
    output logic [1:0]  controlBus0,
    output logic [1:0]  controlBus1,
    output logic [1:0]  controlBus2,
    output logic        frameStart,
    output logic        lineStart,
    output logic        underrun,
    output logic        running
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_FP_START = 12'(H_ACTIVE);
    localparam logic [11:0] H_SY_START = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_BP_START = 12'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_FP_START = 12'(V_ACTIVE);
    localparam logic [11:0] V_SY_START = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_BP_START = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } top_state_t;

    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FP  = 2'd1,
        H_SY  = 2'd2,
        H_BP  = 2'd3
    } h_phase_t;

    typedef enum logic [1:0] {
        V_ACT = 2'd0,
        V_FP  = 2'd1,
        V_SY  = 2'd2,
        V_BP  = 2'd3
    } v_phase_t;

    top_state_t  state, state_next;
    h_phase_t    h_phase, h_phase_next;
    v_phase_t    v_phase, v_phase_next;
    logic [11:0] h_count, h_count_next;
    logic [11:0] v_count, v_count_next;

    logic        h_wrap;
    logic        frame_wrap;
    logic        run;

    // Stage-1 sync qualifiers, delayed one more cycle into controlBus0.
    logic        hsync_act_s1;
    logic        vsync_act_s1;

    // The phase registers are loaded with the decode of the next count,
    // so they always agree with the count they sit beside.
    function automatic h_phase_t h_decode(input logic [11:0] cnt);
        if (cnt < H_FP_START)      return H_ACT;
        else if (cnt < H_SY_START) return H_FP;
        else if (cnt < H_BP_START) return H_SY;
        else                       return H_BP;
    endfunction

    function automatic v_phase_t v_decode(input logic [11:0] cnt);
        if (cnt < V_FP_START)      return V_ACT;
        else if (cnt < V_SY_START) return V_FP;
        else if (cnt < V_BP_START) return V_SY;
        else                       return V_BP;
    endfunction

    assign run        = (state == ST_RUN);
    assign h_wrap     = (h_count == H_LAST);
    assign frame_wrap = h_wrap && (v_count == V_LAST);

    // -----------------------------------------------------------------------
    // Top FSM, counters and phase FSMs: state registers
    // -----------------------------------------------------------------------
    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            state   <= ST_IDLE;
            h_count <= 12'd0;
            v_count <= 12'd0;
            h_phase <= H_ACT;
            v_phase <= V_ACT;
        end else begin
            state   <= state_next;
            h_count <= h_count_next;
            v_count <= v_count_next;
            h_phase <= h_phase_next;
            v_phase <= v_phase_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        h_count_next = h_count;
        v_count_next = v_count;

        case (state)
            ST_IDLE: begin
                h_count_next = 12'd0;
                v_count_next = 12'd0;
                if (videoEnable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_wrap) begin
                    h_count_next = 12'd0;
                    v_count_next = (v_count == V_LAST) ? 12'd0 : v_count + 12'd1;
                end else begin
                    h_count_next = h_count + 12'd1;
                end
                // Re-asserting videoEnable on the wrap cycle gives back-to-back frames.
                if (frame_wrap && !videoEnable) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                h_count_next = 12'd0;
                v_count_next = 12'd0;
            end
        endcase

        h_phase_next = h_decode(h_count_next);
        v_phase_next = v_decode(v_count_next);
    end

    // -----------------------------------------------------------------------
    // Stage 1: requests, coordinates and markers
    // -----------------------------------------------------------------------
    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            pixelReq     <= 1'b0;
            pixelX       <= 12'd0;
            pixelY       <= 12'd0;
            lineStart    <= 1'b0;
            frameStart   <= 1'b0;
            hsync_act_s1 <= 1'b0;
            vsync_act_s1 <= 1'b0;
        end else begin
            pixelReq     <= run && (h_phase == H_ACT) && (v_phase == V_ACT);
            if (run && (h_phase == H_ACT) && (v_phase == V_ACT)) begin
                pixelX <= h_count;
                pixelY <= v_count;
            end
            lineStart    <= run && (h_count == 12'd0);
            frameStart   <= run && (h_count == 12'd0) && (v_count == 12'd0);
            hsync_act_s1 <= run && (h_phase == H_SY);
            vsync_act_s1 <= run && (v_phase == V_SY);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: DE and sync words, aligned with the pixel data
    // -----------------------------------------------------------------------
    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            DE          <= 1'b0;
            controlBus0 <= {~VSYNC_POL, ~HSYNC_POL};
        end else begin
            DE          <= pixelReq;
            controlBus0 <= {(vsync_act_s1 ? VSYNC_POL : ~VSYNC_POL),
                            (hsync_act_s1 ? HSYNC_POL : ~HSYNC_POL)};
        end
    end

    // -----------------------------------------------------------------------
    // Underrun: the source owes data on every DE cycle. A new underrun in the
    // same cycle as a clear keeps the flag set so no event is lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            underrun <= 1'b0;
        end else if (DE && !pixelValid) begin
            underrun <= 1'b1;
        end else if (clearUnderrun) begin
            underrun <= 1'b0;
        end
    end

    assign running     = run;
    assign controlBus1 = 2'b00;
    assign controlBus2 = 2'b00;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for video_timing_ctrl with a small raster (H 8/2/3/1, V 4/1/2/1:
// 14-cycle lines, 112-cycle frames). A reference model tracks the raster as
// a linear position within the frame and pushes the expected outputs of every
// cycle into a status queue, and each expected pixel request into a pixel
// queue. A monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_video_timing_ctrl;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 1;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        rstN;
    logic        videoEnable;
    logic        pixelValid;
    logic        clearUnderrun;
    logic        pixelReq;
    logic [11:0] pixelX;
    logic [11:0] pixelY;
    logic        DE;
    logic [1:0]  controlBus0;
    logic [1:0]  controlBus1;
    logic [1:0]  controlBus2;
    logic        frameStart;
    logic        lineStart;
    logic        underrun;
    logic        running;

    video_timing_ctrl #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .pixelClk     (clk),
        .rstN         (rstN),
        .videoEnable  (videoEnable),
        .pixelValid   (pixelValid),
        .clearUnderrun(clearUnderrun),
        .pixelReq     (pixelReq),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .DE           (DE),
        .controlBus0  (controlBus0),
        .controlBus1  (controlBus1),
        .controlBus2  (controlBus2),
        .frameStart   (frameStart),
        .lineStart    (lineStart),
        .underrun     (underrun),
        .running      (running)
    );

    typedef struct packed {
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        de;
        logic [1:0]  cb0;
        logic        fs;
        logic        ls;
        logic        ur;
        logic        run;
    } exp_t;

    exp_t        status_q[$];
    logic [23:0] pix_q[$];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raster helpers on a linear frame position.
    function automatic bit in_active(input bit r, input int pos);
        return r && (pos % HT) < HA && (pos / HT) < VA;
    endfunction

    function automatic bit in_hsync(input bit r, input int pos);
        return r && (pos % HT) >= HA + HF && (pos % HT) < HA + HF + HS;
    endfunction

    function automatic bit in_vsync(input bit r, input int pos);
        return r && (pos / HT) >= VA + VF && (pos / HT) < VA + VF + VS;
    endfunction

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    initial begin : model
        bit          m_run;
        int          m_pos;
        bit          d_run;
        int          d_pos;
        logic [11:0] last_x;
        logic [11:0] last_y;
        logic        prev_de;
        logic        prev_ur;
        logic        s_rst, s_ve, s_pv, s_clr;
        exp_t        e;
        m_run = 0; m_pos = 0; d_run = 0; d_pos = 0;
        last_x = '0; last_y = '0; prev_de = 0; prev_ur = 0;
        forever begin
            @(posedge clk);
            s_rst = rstN; s_ve = videoEnable; s_pv = pixelValid; s_clr = clearUnderrun;
            #3;
            e = '0;
            if (!s_rst || !rstN) begin
                m_run = 0; m_pos = 0; d_run = 0; d_pos = 0;
                last_x = '0; last_y = '0;
                e.cb0 = 2'b11;
            end else begin
                e.de  = in_active(d_run, d_pos);
                e.cb0 = {~in_vsync(d_run, d_pos), ~in_hsync(d_run, d_pos)};
                e.ur  = (prev_de && !s_pv) ? 1'b1 : (s_clr ? 1'b0 : prev_ur);
                e.req = in_active(m_run, m_pos);
                if (e.req) begin
                    last_x = 12'(m_pos % HT);
                    last_y = 12'(m_pos / HT);
                end
                e.ls = m_run && (m_pos % HT) == 0;
                e.fs = m_run && m_pos == 0;
                d_run = m_run;
                d_pos = m_pos;
                if (!m_run || m_pos == FRAME - 1) begin
                    m_pos = 0;
                    m_run = s_ve;
                end else begin
                    m_pos++;
                end
                e.run = m_run;
            end
            e.x = last_x;
            e.y = last_y;
            prev_de = e.de;
            prev_ur = e.ur;
            status_q.push_back(e);
            if (e.req) pix_q.push_back({e.x, e.y});
        end
    end

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    initial begin : monitor
        exp_t        e;
        logic [23:0] p;
        forever begin
            @(negedge clk);
            if (status_q.size() == 0) begin
                chk("status_available", 0, 1);
            end else begin
                e = status_q.pop_front();
                chk("pixelReq",    pixelReq,    e.req);
                chk("pixelX",      pixelX,      e.x);
                chk("pixelY",      pixelY,      e.y);
                chk("DE",          DE,          e.de);
                chk("controlBus0", controlBus0, e.cb0);
                chk("frameStart",  frameStart,  e.fs);
                chk("lineStart",   lineStart,   e.ls);
                chk("underrun",    underrun,    e.ur);
                chk("running",     running,     e.run);
                chk("controlBus1", controlBus1, 0);
                chk("controlBus2", controlBus2, 0);
            end
            if (pixelReq === 1'b1) begin
                if (pix_q.size() == 0) begin
                    chk("pixel_unexpected", 1, 0);
                end else begin
                    p = pix_q.pop_front();
                    chk("pixel_xy", {pixelX, pixelY}, p);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_cycles(input int n, input int toggle_odds);
        for (int i = 0; i < n; i++) begin
            tick();
            pixelValid    = ($urandom_range(0, 15) != 0);
            clearUnderrun = ($urandom_range(0, 7) == 0);
            if (toggle_odds > 0 && $urandom_range(0, toggle_odds - 1) == 0)
                videoEnable = ~videoEnable;
        end
    endtask

    initial begin : stim
        bit found;
        rstN = 1'b0; videoEnable = 1'b0; pixelValid = 1'b1; clearUnderrun = 1'b0;
        repeat (3) tick();
        rstN = 1'b1;
        repeat (100) tick();

        // Continuous run with random source gaps and clears.
        videoEnable = 1'b1;
        rand_cycles(2 * FRAME + 20, 0);

        // Mid-frame stop: frame completes, then idle; then restart.
        pixelValid = 1'b1; clearUnderrun = 1'b0;
        tick();
        videoEnable = 1'b0;
        repeat (2 * FRAME) tick();
        videoEnable = 1'b1;
        repeat (FRAME) tick();

        // Asynchronous reset while pixel 3 of a line is being requested.
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            tick();
            if (pixelReq === 1'b1 && pixelX == 12'd3) found = 1;
        end
        if (!found) chk("reach_pixel3", 0, 1);
        tick();
        rstN = 1'b0;
        #1;
        chk("async_rst_DE",          DE,          0);
        chk("async_rst_controlBus0", controlBus0, 2'b11);
        chk("async_rst_pixelReq",    pixelReq,    0);
        chk("async_rst_running",     running,     0);
        repeat (3) tick();
        rstN = 1'b1;
        repeat (FRAME + 10) tick();

        // Random enable toggling, including around frame boundaries.
        rand_cycles(1500, 150);

        videoEnable = 1'b0; pixelValid = 1'b1; clearUnderrun = 1'b1;
        repeat (2 * FRAME) tick();
        tick();
        chk("pixel_queue_drained", pix_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Sequencer for the three TMDS encoder/serializer lanes. It generates the raster timing on the pixel clock: display enable (DE), per-lane control bus values, pixel requests and coordinates toward the pixel source, and frame/line markers. It also tracks source underruns. It sits between the frame/pixel source and the three `encoder_serializer` instances and drives their `DE` and `controlBus` inputs.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted hsync level (0 = active-low)
- VSYNC_POL, 0, asserted vsync level
- pixelClk  in  1  pixel clock; single clock domain
- rstN  in  1  reset, asynchronous, active-low
- videoEnable  in  1  run request
- pixelValid  in  1  source has data on lanes this cycle
- clearUnderrun  in  1  clears the underrun flag
- pixelReq  out  1  source must present pixel (pixelX, pixelY) on the next cycle
- pixelX  out  12  column of the requested pixel
- pixelY  out  12  row of the requested pixel
- DE  out  1  to all three encoders
- controlBus0  out  2  {vsync, hsync} to the blue lane
- controlBus1  out  2  to the green lane; constant 2'b00
- controlBus2  out  2  to the red lane; constant 2'b00
- frameStart  out  1  one-cycle pulse at the first pixel of a frame
- lineStart  out  1  one-cycle pulse at the first pixel of each line
- underrun  out  1  sticky; set when a source underrun occurs
- running  out  1  a frame is in progress

## Operation
- **Reset values.** All outputs are 0 except controlBus0, which is {~VSYNC_POL, ~HSYNC_POL}; the default is 2'b11. The FSM is in IDLE and the counters are 0.
- **Top FSM.**
  - IDLE → RUN on a cycle with videoEnable=1. The first counted cycle is (hCount=0, vCount=0).
  - RUN → IDLE when the frame wrap occurs (hCount=H_TOTAL-1, vCount=V_TOTAL-1) with videoEnable=0. The current frame always completes, so a mid-frame deassert has no visible effect until the frame end.
  - In IDLE, DE=0, sync outputs are inactive, and no requests are issued.
- **Horizontal phase FSM.** States are H_ACT, H_FP, H_SY, H_BP.
  - The phase follows hCount: [0, H_ACTIVE), then FP, then SY, then BP.
  - H_TOTAL = sum of the four horizontal parameters; V_TOTAL is defined likewise.
  - hCount wraps from H_TOTAL-1 to 0. vCount increments on each hCount wrap and wraps from V_TOTAL-1 to 0.
- **Vertical phases.** V_ACT, V_FP, V_SY, V_BP are decoded from vCount in the same way.
- **Stage 1 (registered from the counters).**
  - pixelReq = RUN & H_ACT & V_ACT.
  - pixelX = hCount and pixelY = vCount when pixelReq=1; otherwise both hold their last value.
  - lineStart = RUN & (hCount==0).
  - frameStart = lineStart & (vCount==0).
- **Stage 2 (registered from stage 1).**
  - DE = the stage-1 pixelReq.
  - hsync = HSYNC_POL when in H_SY, else ~HSYNC_POL.
  - vsync is derived the same way from V_SY. Both are delayed to align with DE.
  - controlBus0 = {vsync, hsync}.
- **Underrun.** The flag is set on any cycle with DE=1 and pixelValid=0. clearUnderrun clears it; a set on the same cycle as clearUnderrun wins.
- **running.** running=1 while in RUN.
- **Counter widths.** Counters are 12 bits. Parameters must satisfy H_TOTAL, V_TOTAL ≤ 4095; this is not checked in RTL.

## Timing
- **Latency.** Counter state at cycle t produces pixelReq, pixelX, pixelY, lineStart and frameStart at t+1, and DE, controlBus0 and the underrun check at t+2.
- **Pixel handshake.** The source presents the pixel on the cycle after pixelReq, which is the cycle DE=1. It has no back-pressure; the raster never stalls.
- **Line and frame lengths.**
  - DE is high for exactly H_ACTIVE consecutive cycles per active line.
  - Each line is H_TOTAL cycles; each frame is H_TOTAL·V_TOTAL cycles.
- **Sync position in a line.** Relative to the DE rising edge, hsync asserts at cycle offset H_ACTIVE+H_FRONT and lasts H_SYNC cycles.
- **Sync position in a frame.** vsync asserts on lines V_ACTIVE+V_FRONT through V_ACTIVE+V_FRONT+V_SYNC-1. It changes coincident with the hsync-phase-aligned line start, i.e. at hCount=0 of that line.
- **Restart after IDLE.** frameStart occurs 2 cycles after the IDLE→RUN edge (1 cycle after the counters begin at 0,0).
- **Simultaneous events.** videoEnable re-asserted on the stop cycle keeps the FSM in RUN with no gap between frames.
- **Reset mid-operation.** Reset asynchronously forces all outputs to their reset values immediately, including pipeline stages. After release, the FSM waits in IDLE for videoEnable.

## Test plan
- **Reset values.** Hold rstN=0, then release with videoEnable=0 → DE=0, controlBus0=2'b11, pixelReq=0, running=0 held for 100 cycles.
- **Line timing.** Small parameters H 8/2/3/1, V 4/1/2/1, run one line → pixelReq on 8 cycles (pixelX 0..7); DE the same 8 cycles delayed by 1; hsync low for 3 cycles starting 10 cycles after DE rises; line period 14.
- **Frame timing.**
  - With the same parameters → frameStart every 112 cycles; DE high on 4 lines.
  - controlBus0 = 2'b01 (vsync low) during lines 5–6; 2'b00 when both are low.
  - With defaults → frameStart period 420000.
- **Stop at frame end.** Deassert videoEnable mid-frame → frame completes, running falls after the last pixel of line V_TOTAL-1, and no further pixelReq is issued. Re-assert → frameStart after 2 cycles.
- **Underrun.**
  - Drive pixelValid=0 for one DE cycle → underrun=1 the next cycle, held.
  - clearUnderrun → 0.
  - clearUnderrun together with a new underrun → stays 1.
- **Reset mid-line.** Assert rstN=0 at pixelX=3 → DE=0 and controlBus0=2'b11 asynchronously. After release and enable, frame restarts at (0,0).
